// File: rtl/sampler_pkg.sv
// Shared state encodings for the sampler trigger FSM, its CSR wrapper and the bench.
package sampler_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_DELAY   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // The sampler is released from reset only while it is filling or holding data.
    function automatic logic sampler_live(state_t s);
        return (s == ST_CAPTURE) || (s == ST_DONE);
    endfunction

endpackage

// File: rtl/trigger_match.sv
// Masked pattern match with optional rising-edge qualification.
module trigger_match #(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [width-1:0] sample_in,
    input  logic [width-1:0] mask,
    input  logic [width-1:0] value,
    input  logic             edge_sel,
    output logic             trig
);

    logic match;
    logic prev_match;

    assign match = ((sample_in ^ value) & mask) == '0;

    // Tracks the match every cycle regardless of FSM state, so an edge trigger
    // never fires on a pattern that was already present when the block was armed.
    always_ff @(posedge clk) begin
        if (reset) prev_match <= 1'b0;
        else       prev_match <= match;
    end

    assign trig = edge_sel ? (match && !prev_match) : match;

endmodule

// File: rtl/sampler_trigger.sv
// Trigger sequencer for a capture sampler: arm, match, optional delay, capture, done.
module sampler_trigger
    import sampler_pkg::*;
#(
    parameter int width     = 32,
    parameter int delayBits = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [width-1:0]     sample_in,
    input  logic [width-1:0]     trig_mask,
    input  logic [width-1:0]     trig_value,
    input  logic                 trig_edge,
    input  logic [delayBits-1:0] delay,
    input  logic                 arm,
    input  logic                 abort,
    input  logic                 cap_done,
    output logic                 cap_reset_n,
    output logic [STATE_W-1:0]   state,
    output logic                 irq,
    input  logic                 irq_ack,
    output logic [7:0]           capture_count
);

    state_t               cur, nxt;
    logic [delayBits-1:0] delay_cnt;
    logic                 trig;
    logic                 load_cnt;
    logic                 done_evt;

    trigger_match #(.width(width)) u_match (
        .clk      (clk),
        .reset    (reset),
        .sample_in(sample_in),
        .mask     (trig_mask),
        .value    (trig_value),
        .edge_sel (trig_edge),
        .trig     (trig)
    );

    always_comb begin
        nxt      = cur;
        load_cnt = 1'b0;
        done_evt = 1'b0;
        case (cur)
            ST_IDLE:    if (arm) nxt = ST_ARMED;
            ST_ARMED: begin
                if (trig) begin
                    if (delay != '0) begin
                        nxt      = ST_DELAY;
                        load_cnt = 1'b1;
                    end else begin
                        nxt = ST_CAPTURE;
                    end
                end
            end
            ST_DELAY:   if (delay_cnt == '0) nxt = ST_CAPTURE;
            ST_CAPTURE: begin
                if (cap_done) begin
                    nxt      = ST_DONE;
                    done_evt = 1'b1;
                end
            end
            ST_DONE:    if (arm) nxt = ST_ARMED;
            default:    nxt = ST_IDLE;
        endcase
        if (abort) begin
            nxt      = ST_IDLE;
            load_cnt = 1'b0;
            done_evt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur           <= ST_IDLE;
            delay_cnt     <= '0;
            cap_reset_n   <= 1'b0;
            irq           <= 1'b0;
            capture_count <= '0;
        end else begin
            cur <= nxt;
            // Loading delay-1 and leaving on zero yields exactly `delay` DELAY cycles.
            if (load_cnt)
                delay_cnt <= delay - 1'b1;
            else if (cur == ST_DELAY && delay_cnt != '0)
                delay_cnt <= delay_cnt - 1'b1;
            // Follows the current state, so it lags entry into CAPTURE by one edge
            // and the sampler sees at least one cycle of address clear.
            cap_reset_n <= sampler_live(cur);
            if (done_evt) begin
                irq           <= 1'b1;
                capture_count <= capture_count + 8'd1;
            end else if (irq_ack) begin
                irq <= 1'b0;
            end
        end
    end

    assign state = cur;

endmodule

// File: tb/tb_sampler_trigger.sv
// Self-checking bench for sampler_trigger: directed scenarios plus a randomized capture model.
module tb_sampler_trigger;
    import sampler_pkg::*;

    localparam int W  = 32;
    localparam int DB = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  sample_in, trig_mask, trig_value;
    logic          trig_edge;
    logic [DB-1:0] delay;
    logic          arm, abort, cap_done, irq_ack;
    logic          cap_reset_n;
    logic [2:0]    state;
    logic          irq;
    logic [7:0]    capture_count;

    int checks = 0;
    int errors = 0;
    int exp_count = 0;

    logic [12:0] obs, e;
    assign obs = {state, cap_reset_n, irq, capture_count};

    always #5 clk = ~clk;

    sampler_trigger #(.width(W), .delayBits(DB)) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_in    (sample_in),
        .trig_mask    (trig_mask),
        .trig_value   (trig_value),
        .trig_edge    (trig_edge),
        .delay        (delay),
        .arm          (arm),
        .abort        (abort),
        .cap_done     (cap_done),
        .cap_reset_n  (cap_reset_n),
        .state        (state),
        .irq          (irq),
        .irq_ack      (irq_ack),
        .capture_count(capture_count)
    );

    function automatic logic [12:0] pk(int st, bit crn, bit irq_v, int cnt);
        return {3'(st), crn, irq_v, 8'(cnt)};
    endfunction

    function automatic string show(logic [12:0] v);
        return $sformatf("st=%0d crn=%0b irq=%0b cnt=%0d", v[12:10], v[9], v[8], v[7:0]);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; arm = 0; abort = 0; cap_done = 0; irq_ack = 0;
        sample_in = '0; trig_mask = '0; trig_value = '0; trig_edge = 0; delay = '0;
        tick; tick;
        reset = 1'b0;
        exp_count = 0;
        e = pk(ST_IDLE, 0, 0, 0);
        checks++; if (obs !== e) begin errors++; $display("FAIL reset_state got %s want %s", show(obs), show(e)); end
        tick;
        checks++; if (obs !== e) begin errors++; $display("FAIL reset_idle_hold got %s want %s", show(obs), show(e)); end
    endtask

    task automatic test_basic;
        trig_mask = '0; trig_value = $urandom; sample_in = $urandom; delay = '0; trig_edge = 0;
        arm = 1; tick; arm = 0;
        e = pk(ST_ARMED, 0, 0, 0);
        checks++; if (obs !== e) begin errors++; $display("FAIL basic_armed got %s want %s", show(obs), show(e)); end
        tick;
        e = pk(ST_CAPTURE, 0, 0, 0);
        checks++; if (obs !== e) begin errors++; $display("FAIL basic_capture got %s want %s", show(obs), show(e)); end
        tick;
        e = pk(ST_CAPTURE, 1, 0, 0);
        checks++; if (obs !== e) begin errors++; $display("FAIL basic_crn got %s want %s", show(obs), show(e)); end
        repeat (16) tick;
        cap_done = 1; tick; cap_done = 0;
        exp_count = 1;
        e = pk(ST_DONE, 1, 1, 1);
        checks++; if (obs !== e) begin errors++; $display("FAIL basic_done got %s want %s", show(obs), show(e)); end
    endtask

    task automatic test_edge;
        irq_ack = 1; tick; irq_ack = 0;
        e = pk(ST_DONE, 1, 0, 1);
        checks++; if (obs !== e) begin errors++; $display("FAIL edge_ack got %s want %s", show(obs), show(e)); end
        trig_edge = 1; trig_mask = 32'hFF; trig_value = 32'h5A; sample_in = 32'h5A; delay = '0;
        tick;
        arm = 1; tick;
        e = pk(ST_ARMED, 1, 0, 1);
        checks++; if (obs !== e) begin errors++; $display("FAIL edge_rearm got %s want %s", show(obs), show(e)); end
        tick; arm = 0;
        e = pk(ST_ARMED, 0, 0, 1);
        checks++; if (obs !== e) begin errors++; $display("FAIL edge_arm_ignored got %s want %s", show(obs), show(e)); end
        tick;
        checks++; if (obs !== e) begin errors++; $display("FAIL edge_held_level got %s want %s", show(obs), show(e)); end
        sample_in = 32'h00; tick;
        checks++; if (obs !== e) begin errors++; $display("FAIL edge_low got %s want %s", show(obs), show(e)); end
        sample_in = 32'h5A; tick;
        e = pk(ST_CAPTURE, 0, 0, 1);
        checks++; if (obs !== e) begin errors++; $display("FAIL edge_rise got %s want %s", show(obs), show(e)); end
        tick;
        cap_done = 1; tick; cap_done = 0;
        exp_count = 2;
        e = pk(ST_DONE, 1, 1, 2);
        checks++; if (obs !== e) begin errors++; $display("FAIL edge_done got %s want %s", show(obs), show(e)); end
    endtask

    task automatic test_delay;
        int ndel, rise;
        irq_ack = 1; tick; irq_ack = 0;
        trig_edge = 0; trig_mask = 32'hFF; trig_value = 32'h5A; sample_in = 32'h00; delay = 16'd3;
        arm = 1; tick; arm = 0;
        e = pk(ST_ARMED, 1, 0, 2);
        checks++; if (obs !== e) begin errors++; $display("FAIL delay_armed got %s want %s", show(obs), show(e)); end
        tick;
        sample_in = 32'h5A; tick;
        e = pk(ST_DELAY, 0, 0, 2);
        checks++; if (obs !== e) begin errors++; $display("FAIL delay_enter got %s want %s", show(obs), show(e)); end
        ndel = 1; rise = 0;
        for (int k = 1; k <= 5; k++) begin
            arm = (k == 1);
            tick;
            if (state == 3'd2) ndel++;
            if (cap_reset_n && rise == 0) rise = k;
        end
        arm = 0;
        checks++; if (ndel !== 3) begin errors++; $display("FAIL delay_cycles got %0d want 3", ndel); end
        checks++; if (rise !== 4) begin errors++; $display("FAIL delay_crn_rise got %0d want 4", rise); end
        e = pk(ST_CAPTURE, 1, 0, 2);
        checks++; if (obs !== e) begin errors++; $display("FAIL delay_capture got %s want %s", show(obs), show(e)); end
        cap_done = 1; tick; cap_done = 0;
        exp_count = 3;
        irq_ack = 1; tick; irq_ack = 0;
        e = pk(ST_DONE, 1, 0, 3);
        checks++; if (obs !== e) begin errors++; $display("FAIL delay_done got %s want %s", show(obs), show(e)); end
    endtask

    task automatic test_abort;
        trig_mask = '0; trig_edge = 0; delay = 16'd5;
        arm = 1; tick; arm = 0;
        tick; tick;
        e = pk(ST_DELAY, 0, 0, 3);
        checks++; if (obs !== e) begin errors++; $display("FAIL abort_pre_delay got %s want %s", show(obs), show(e)); end
        abort = 1; tick; abort = 0;
        e = pk(ST_IDLE, 0, 0, 3);
        checks++; if (obs !== e) begin errors++; $display("FAIL abort_delay got %s want %s", show(obs), show(e)); end
        delay = '0;
        arm = 1; tick; arm = 0;
        tick; tick;
        e = pk(ST_CAPTURE, 1, 0, 3);
        checks++; if (obs !== e) begin errors++; $display("FAIL abort_pre_cap got %s want %s", show(obs), show(e)); end
        abort = 1; cap_done = 1; tick; abort = 0; cap_done = 0;
        e = pk(ST_IDLE, 1, 0, 3);
        checks++; if (obs !== e) begin errors++; $display("FAIL abort_capture got %s want %s", show(obs), show(e)); end
        tick;
        e = pk(ST_IDLE, 0, 0, 3);
        checks++; if (obs !== e) begin errors++; $display("FAIL abort_crn_drop got %s want %s", show(obs), show(e)); end
        abort = 1; arm = 1; tick; abort = 0; arm = 0;
        checks++; if (obs !== e) begin errors++; $display("FAIL abort_arm_idle got %s want %s", show(obs), show(e)); end
        arm = 1; tick; arm = 0; tick;
        cap_done = 1; tick; cap_done = 0;
        exp_count = 4;
        abort = 1; arm = 1; tick; abort = 0; arm = 0;
        e = pk(ST_IDLE, 1, 1, 4);
        checks++; if (obs !== e) begin errors++; $display("FAIL abort_arm_done got %s want %s", show(obs), show(e)); end
        irq_ack = 1; tick; irq_ack = 0;
        arm = 1; tick; arm = 0; tick; tick;
        e = pk(ST_CAPTURE, 1, 0, 4);
        checks++; if (obs !== e) begin errors++; $display("FAIL rst_pre_cap got %s want %s", show(obs), show(e)); end
        reset = 1; cap_done = 1; tick; reset = 0; cap_done = 0;
        exp_count = 0;
        e = pk(ST_IDLE, 0, 0, 0);
        checks++; if (obs !== e) begin errors++; $display("FAIL rst_mid_capture got %s want %s", show(obs), show(e)); end
    endtask

    task automatic test_irq_ack;
        trig_mask = '0; delay = '0;
        arm = 1; tick; arm = 0; tick;
        cap_done = 1; irq_ack = 1; tick; cap_done = 0; irq_ack = 0;
        exp_count = 1;
        e = pk(ST_DONE, 1, 1, 1);
        checks++; if (obs !== e) begin errors++; $display("FAIL irq_set_wins got %s want %s", show(obs), show(e)); end
        tick;
        checks++; if (obs !== e) begin errors++; $display("FAIL irq_held got %s want %s", show(obs), show(e)); end
        irq_ack = 1; tick; irq_ack = 0;
        e = pk(ST_DONE, 1, 0, 1);
        checks++; if (obs !== e) begin errors++; $display("FAIL irq_cleared got %s want %s", show(obs), show(e)); end
    endtask

    // Reference: arm at step 0, ARMED until the first matching step t, then d steps
    // of DELAY, CAPTURE until cap_done is seen, DONE afterwards; cap_reset_n is 1
    // exactly when the previous step's state was CAPTURE or DONE.
    task automatic test_random;
        int prev_st = ST_DONE;
        for (int it = 0; it < 16; it++) begin
            int d  = $urandom_range(0, 6);
            int wl = $urandom_range(0, 4);
            int l  = $urandom_range(0, 4);
            int t  = wl + 1;
            int kd = t + d + 1 + l;
            logic [W-1:0] m = $urandom | 32'h1;
            logic [W-1:0] v = $urandom;
            trig_mask = m; trig_value = v; trig_edge = 0; delay = 16'(d);
            for (int k = 0; k <= kd; k++) begin
                int xs;
                logic [W-1:0] base;
                base = (v & m) | ($urandom & ~m);
                sample_in = (k >= t) ? base : (base ^ 32'h1);
                arm = (k == 0);
                cap_done = (k == kd);
                tick;
                if (k < t)          xs = ST_ARMED;
                else if (k < t + d) xs = ST_DELAY;
                else if (k < kd)    xs = ST_CAPTURE;
                else                xs = ST_DONE;
                if (k == kd) exp_count++;
                e = pk(xs, (prev_st == ST_CAPTURE || prev_st == ST_DONE), (k == kd), exp_count);
                checks++; if (obs !== e) begin errors++; $display("FAIL rand_it%0d_k%0d got %s want %s", it, k, show(obs), show(e)); end
                prev_st = xs;
            end
            arm = 0; cap_done = 0;
            irq_ack = 1; tick; irq_ack = 0;
            e = pk(ST_DONE, 1, 0, exp_count);
            checks++; if (obs !== e) begin errors++; $display("FAIL rand_ack_it%0d got %s want %s", it, show(obs), show(e)); end
        end
    endtask

    task automatic test_back_to_back;
        reset = 1; tick; reset = 0;
        trig_mask = '0; delay = '0;
        for (int i = 0; i < 256; i++) begin
            arm = 1; tick; arm = 0; tick;
            cap_done = 1; tick; cap_done = 0;
            e = pk(ST_DONE, 1, 1, (i + 1) % 256);
            checks++; if (obs !== e) begin errors++; $display("FAIL b2b_%0d got %s want %s", i, show(obs), show(e)); end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_edge;
        test_delay;
        test_abort;
        test_irq_ack;
        test_random;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sampler_trigger.md
SAMPLER_TRIGGER -- requirements
Module: sampler_trigger

Interface
REQ-001 The block SHALL have parameter width, default 32, sample bus width in bits.
REQ-002 The block SHALL have parameter delayBits, default 16, width of the post-trigger delay counter.
REQ-003 The block SHALL have port clk  input  1  the single clock; all logic on posedge clk.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port sample_in  input  width  live sample bus, also wired to the sampler's w_in.
REQ-006 The block SHALL have port trig_mask  input  width  bits that take part in the match; a 1 means compared.
REQ-007 The block SHALL have port trig_value  input  width  required value of the compared bits.
REQ-008 The block SHALL have port trig_edge  input  1  0 = level trigger, 1 = rising-edge-of-match trigger.
REQ-009 The block SHALL have port delay  input  delayBits  cycles from trigger to capture start.
REQ-010 The block SHALL have port arm  input  1  single-cycle pulse that starts a capture sequence.
REQ-011 The block SHALL have port abort  input  1  single-cycle pulse that returns the block to IDLE.
REQ-012 The block SHALL have port cap_done  input  1  the sampler's w_done.
REQ-013 The block SHALL have port cap_reset_n  output  1  drives the sampler's w_reset_n.
REQ-014 The block SHALL have port state  output  3  current state encoding.
REQ-015 The block SHALL have port irq  output  1  capture-complete interrupt, held until irq_ack.
REQ-016 The block SHALL have port irq_ack  input  1  clears irq.
REQ-017 The block SHALL have port capture_count  output  8  count of completed captures; wraps from 255 to 0.

Function
REQ-018 Match SHALL be ((sample_in ^ trig_value) & trig_mask) == 0, so trig_mask = 0 always matches.
REQ-019 A registered prev_match SHALL hold the previous cycle's match; it is updated every cycle in every state.
REQ-020 The edge trigger SHALL be match && !prev_match; the level trigger SHALL be match.
REQ-021 The states SHALL be IDLE=0, ARMED=1, DELAY=2, CAPTURE=3, DONE=4.
REQ-022 IDLE SHALL go to ARMED on arm.
REQ-023 ARMED SHALL go on trigger to DELAY if delay != 0, or to CAPTURE if delay == 0.
REQ-024 Entering DELAY SHALL load the counter with delay-1; DELAY SHALL go to CAPTURE in the cycle after the counter reads 0, giving exactly delay cycles in DELAY.
REQ-025 CAPTURE SHALL go to DONE in the cycle after cap_done is sampled high; that transition SHALL set irq and increment capture_count.
REQ-026 DONE SHALL go to ARMED on arm (re-arm).
REQ-027 abort SHALL force IDLE from any state on the next cycle; if abort and arm occur together, abort wins.
REQ-028 arm SHALL be ignored in ARMED, DELAY and CAPTURE.
REQ-029 cap_reset_n SHALL be a registered output: 1 in CAPTURE and DONE, 0 in all other states, so the sampler clears its address before each capture and keeps its data while DONE.
REQ-030 irq SHALL be set by the CAPTURE-to-DONE transition and cleared by irq_ack; if both occur in the same cycle, set wins.
REQ-031 Trigger latency: a trigger sampled at edge N SHALL give state CAPTURE and cap_reset_n = 1 after edge N+1 + delay.

Reset
REQ-032 reset SHALL give state = IDLE, cap_reset_n = 0, irq = 0, capture_count = 0, prev_match = 0 and delay counter = 0.
REQ-033 reset in mid-capture SHALL drop cap_reset_n on the next edge, abandoning the capture with no irq.

Structure
REQ-034 The state encodings SHALL be placed in a shared package, sampler_pkg, for use by the CSR wrapper and the bench.
REQ-035 The match and edge logic SHALL be one sub-module, trigger_match, with inputs sample_in, mask, value, edge and output trig; the FSM stays in the top module.

Verification
REQ-036 The bench SHALL cover: mask=0, delay=0, arm -> CAPTURE two edges after arm; after 2^timeBits cycles cap_done -> DONE, irq=1, capture_count=1.
REQ-037 The bench SHALL cover: trig_edge=1, mask=0xFF, value=0x5A, sample_in held at 0x5A before arm -> stays ARMED; input goes 0x00 then 0x5A -> triggers.
REQ-038 The bench SHALL cover: delay=3 -> exactly 3 cycles in DELAY, and cap_reset_n rises 4 edges after the trigger edge.
REQ-039 The bench SHALL cover: abort during DELAY and during CAPTURE, and abort with arm in the same cycle -> IDLE, cap_reset_n=0, no irq.
REQ-040 The bench SHALL cover: irq_ack in the same cycle as cap_done completion -> irq=1; a later irq_ack -> irq=0.
REQ-041 The bench SHALL cover: 256 back-to-back re-armed captures -> capture_count wraps to 0.
